spi_master_3wire: RTL



---
 rtl/spi_master_pkg.sv | 32 +++
 rtl/spi_clk_tick.sv | 40 ++++
 rtl/spi_master_3wire.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared types and constants for the 3-wire SPI initiator.
//   state_t     : frame sequencer states
//   FRAME_W etc : 24-bit frame layout (16-bit instruction + 8-bit data)
//   build_frame : packs {rnw, W1:W0=00, addr, wdata} MSB first
package spi_master_pkg;

  localparam int unsigned FRAME_W  = 24;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 13;
  localparam int unsigned RW_BIT   = 23;
  localparam int unsigned TURN_BIT = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic              rnw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata
  );
    logic [INSTR_W-1:0] instr;
    instr = {rnw, 2'b00, addr};
    return {instr, wdata};
  endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// spi_clk_tick: half-period divider for the SPI initiator.
//   i_clk, i_rst : system clock, synchronous active-high reset
//   i_en         : count while high
//   i_clr        : synchronous clear of counter and phase
//   o_tick       : one-cycle pulse on the last cycle of each CLK_DIV window
//   o_phase      : toggles after every tick (0 during the first window)
module spi_clk_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick,
  output logic o_phase
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       r_phase;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (i_en) begin
      if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_tick  = i_en && (r_cnt == LAST);
  assign o_phase = r_phase;

endmodule

// File: rtl/spi_master_3wire.sv
// spi_master_3wire: local-bus to 3-wire SPI initiator (one 24-bit frame per request).
//   sys_clk, sys_reset : clock, synchronous active-high reset
//   req/rnw/addr/wdata : request strobe and fields, taken only in IDLE
//   busy, done, rdata  : status, completion pulse, read byte
//   sclk, ss_n         : SPI clock (idles low) and chip select
//   sdo, sdo_oe, sdi   : split sdio (drive value, drive enable, sampled input)
module spi_master_3wire
  import spi_master_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned IDLE_GAP = 4
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              req,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              sclk,
  output logic              ss_n,
  output logic              sdo,
  output logic              sdo_oe,
  input  logic              sdi
);

  localparam logic [15:0] GAP_LAST = 16'(IDLE_GAP - 1);

  state_t              r_state;
  logic [FRAME_W-1:0]  r_shift;
  logic [DATA_W-1:0]   r_rdata_sr;
  logic [DATA_W-1:0]   r_rdata;
  logic [4:0]          r_bit_idx;
  logic [15:0]         r_gap_cnt;
  logic                r_rnw;
  logic                r_busy;
  logic                r_done;
  logic                r_sclk;
  logic                r_ss_n;
  logic                r_sdo_oe;

  logic w_tick;
  logic w_phase;
  logic w_tick_en;
  logic w_tick_clr;

  assign w_tick_en  = (r_state != IDLE);
  assign w_tick_clr = (r_state == IDLE);

  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk   (sys_clk),
    .i_rst   (sys_reset),
    .i_en    (w_tick_en),
    .i_clr   (w_tick_clr),
    .o_tick  (w_tick),
    .o_phase (w_phase)
  );

  // SETUP consumes phase 0, so inside SHIFT phase=1 marks the sclk-low half
  // (tick there means rise) and phase=0 the high half (tick means fall).
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_rdata_sr <= '0;
      r_rdata    <= '0;
      r_bit_idx  <= '0;
      r_gap_cnt  <= '0;
      r_rnw      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sclk     <= 1'b0;
      r_ss_n     <= 1'b1;
      r_sdo_oe   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_shift   <= build_frame(rnw, addr, wdata);
            r_rnw     <= rnw;
            r_bit_idx <= 5'(FRAME_W - 1);
            r_busy    <= 1'b1;
            r_ss_n    <= 1'b0;
            r_sdo_oe  <= 1'b1;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          if (w_tick) r_state <= SHIFT;
        end
        SHIFT: begin
          if (w_tick) begin
            if (w_phase) begin
              r_sclk <= 1'b1;
              if (r_bit_idx < 5'(DATA_W))
                r_rdata_sr <= {r_rdata_sr[DATA_W-2:0], sdi};
            end else begin
              r_sclk <= 1'b0;
              if (r_bit_idx == '0) begin
                r_state <= HOLD;
              end else begin
                r_bit_idx <= r_bit_idx - 5'd1;
                r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
                // Read turnaround: release sdio once the last instruction bit is done.
                if (r_rnw && (r_bit_idx == 5'(TURN_BIT)))
                  r_sdo_oe <= 1'b0;
              end
            end
          end
        end
        HOLD: begin
          if (w_tick) begin
            r_ss_n    <= 1'b1;
            r_sdo_oe  <= 1'b0;
            r_shift   <= '0;
            r_done    <= 1'b1;
            if (r_rnw) r_rdata <= r_rdata_sr;
            r_gap_cnt <= '0;
            // With a one-cycle gap, the done cycle is already the last gap cycle.
            r_busy    <= (IDLE_GAP > 1);
            r_state   <= GAP;
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
            if ((r_gap_cnt + 16'd1) == GAP_LAST) r_busy <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign rdata  = r_rdata;
  assign sclk   = r_sclk;
  assign ss_n   = r_ss_n;
  assign sdo    = r_shift[RW_BIT];
  assign sdo_oe = r_sdo_oe;

endmodule
